// File: rtl/reglk_prog_ctrl.sv
// reglk_prog_ctrl: programming controller for the sticky register-lock word array.
// Single-outstanding valid/ready requests. Writes OR data into a lock word, reads return it.
// A write to the last word that sets its MSB freezes the array. Only global reset clears it.
// Optional build macro REGLK_PARITY_EN adds one even-parity shadow bit per word and a
// sticky integrity alarm. Without the macro, parity_err_o is tied low.
// ADDR_W must be wide enough to index every word (2**ADDR_W >= NUM_WORDS).
//
// state | meaning
// IDLE  | ready for a request
// EXEC  | one cycle: commit the captured request and register the response
// RESP  | response valid, held until rsp_ready_i
module reglk_prog_ctrl #(
  parameter int NUM_WORDS = 6,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 3
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               req_valid_i,
  output logic                               req_ready_o,
  input  logic                               req_we_i,
  input  logic [ADDR_W-1:0]                  req_addr_i,
  input  logic [DATA_W-1:0]                  req_wdata_i,
  output logic                               rsp_valid_o,
  input  logic                               rsp_ready_i,
  output logic [DATA_W-1:0]                  rsp_rdata_o,
  output logic                               rsp_err_o,
  output logic [NUM_WORDS-1:0][DATA_W-1:0]   reglk_o,
  output logic                               frozen_o,
  output logic                               parity_err_o
);

  localparam logic [ADDR_W:0]   LP_NUM_WORDS = NUM_WORDS[ADDR_W:0];
  localparam logic [ADDR_W-1:0] LP_LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                            r_state;
  logic                              r_we;
  logic [ADDR_W-1:0]                 r_addr;
  logic [DATA_W-1:0]                 r_wdata;
  logic [NUM_WORDS-1:0][DATA_W-1:0]  r_words;
  logic                              r_frozen;
  logic                              r_rsp_valid;
  logic [DATA_W-1:0]                 r_rsp_rdata;
  logic                              r_rsp_err;

  logic                              w_addr_ok;
  logic [DATA_W-1:0]                 w_cur_word;
  logic [DATA_W-1:0]                 w_new_word;
  logic                              w_commit;
  logic                              w_parity_bad;
  logic                              w_parity_err;

  assign w_addr_ok  = ({1'b0, r_addr} < LP_NUM_WORDS);
  assign w_cur_word = w_addr_ok ? r_words[r_addr] : '0;
  assign w_new_word = w_cur_word | r_wdata;
  // A write only lands when the address exists and the array is not frozen.
  assign w_commit   = (r_state == ST_EXEC) && r_we && w_addr_ok && !r_frozen;

`ifdef REGLK_PARITY_EN
  logic [NUM_WORDS-1:0] r_shadow;
  logic [NUM_WORDS-1:0] w_par_mismatch;
  logic                 r_parity_err;

  // Compare each word's live parity against its shadow bit.
  always_comb begin
    w_par_mismatch = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      w_par_mismatch[i] = (^r_words[i]) != r_shadow[i];
    end
  end

  assign w_parity_bad = |w_par_mismatch;
  assign w_parity_err = r_parity_err;

  // Shadow parity follows every commit; the alarm is sticky until global reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_shadow     <= '0;
      r_parity_err <= 1'b0;
    end else begin
      if (w_commit) begin
        r_shadow[r_addr] <= ^w_new_word;
      end
      if (w_parity_bad) begin
        r_parity_err <= 1'b1;
      end
    end
  end

  assign parity_err_o = r_parity_err;
`else
  assign w_parity_bad = 1'b0;
  assign w_parity_err = 1'b0;
  assign parity_err_o = 1'b0;
`endif

  // Request FSM with registered lock array, freeze flag and response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_words     <= '0;
      r_frozen    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_parity_bad) begin
        r_frozen <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (req_valid_i) begin
            r_we    <= req_we_i;
            r_addr  <= req_addr_i;
            r_wdata <= req_wdata_i;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_state     <= ST_RESP;
          r_rsp_valid <= 1'b1;
          if (!w_addr_ok) begin
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= '0;
          end else if (r_we && r_frozen) begin
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= w_cur_word;
          end else if (r_we) begin
            r_words[r_addr] <= w_new_word;
            r_rsp_rdata     <= w_new_word;
            r_rsp_err       <= 1'b0;
            if ((r_addr == LP_LAST_ADDR) && w_new_word[DATA_W-1]) begin
              r_frozen <= 1'b1;
            end
          end else begin
            r_rsp_rdata <= w_cur_word;
            r_rsp_err   <= w_parity_err;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o = (r_state == ST_IDLE) && !rst_i;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rsp_rdata;
  assign rsp_err_o   = r_rsp_err;
  assign reglk_o     = r_words;
  assign frozen_o    = r_frozen;

endmodule

// File: tb/tb_reglk_prog_ctrl.sv
// Bench for reglk_prog_ctrl: directed scenarios followed by random request traffic,
// checked against a behavioural model of the lock array kept in plain arrays.
module tb_reglk_prog_ctrl;

  localparam int NW = 6;
  localparam int DW = 32;
  localparam int AW = 3;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    req_valid = 1'b0;
  logic                    req_ready;
  logic                    req_we = 1'b0;
  logic [AW-1:0]           req_addr = '0;
  logic [DW-1:0]           req_wdata = '0;
  logic                    rsp_valid;
  logic                    rsp_ready = 1'b0;
  logic [DW-1:0]           rsp_rdata;
  logic                    rsp_err;
  logic [NW-1:0][DW-1:0]   reglk;
  logic                    frozen;
  logic                    parity_err;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] m_words [NW];
  logic          m_frozen;

  reglk_prog_ctrl #(.NUM_WORDS(NW), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_err_o    (rsp_err),
    .reglk_o      (reglk),
    .frozen_o     (frozen),
    .parity_err_o (parity_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NW; i++) m_words[i] = '0;
    m_frozen = 1'b0;
  endtask

  // Sticky-lock rules: bad address errors, frozen writes error, writes only set bits.
  task automatic model_op(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          output logic [DW-1:0] rdata, output logic err);
    int a;
    a = int'(addr);
    if (a >= NW) begin
      err = 1'b1; rdata = '0;
    end else if (we && m_frozen) begin
      err = 1'b1; rdata = m_words[a];
    end else if (we) begin
      m_words[a] = m_words[a] | wdata;
      rdata = m_words[a]; err = 1'b0;
      if (a == NW - 1 && m_words[a][DW-1]) m_frozen = 1'b1;
    end else begin
      rdata = m_words[a]; err = 1'b0;
    end
  endtask

  task automatic chk_array(input string tag);
    for (int i = 0; i < NW; i++) chk($sformatf("%s_word%0d", tag, i), reglk[i], m_words[i]);
    chk({tag, "_frozen"}, 32'(frozen), 32'(m_frozen));
    chk({tag, "_parity"}, 32'(parity_err), 32'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready_low", 32'(req_ready), 32'd0);
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk_array("rst");
  endtask

  // One full transaction from IDLE back to IDLE, optionally stalling the response
  // and poking a request during the stall that must be ignored.
  task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input int hold, input bit pulse);
    logic [DW-1:0] e_rdata;
    logic          e_err;
    model_op(we, addr, wdata, e_rdata, e_err);
    @(negedge clk);
    chk("idle_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = AW'($urandom); req_wdata = $urandom;
    chk("exec_ready", 32'(req_ready), 32'd0);
    chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_rdata", rsp_rdata, e_rdata);
    chk("rsp_err", 32'(rsp_err), 32'(e_err));
    chk_array("rsp");
    for (int h = 0; h < hold; h++) begin
      if (pulse && h == 0) begin
        req_valid = 1'b1; req_we = 1'b1; req_addr = AW'($urandom_range(0, NW - 1));
        req_wdata = 32'hFFFF_FFFF;
      end
      @(negedge clk);
      req_valid = 1'b0;
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rsp_rdata, e_rdata);
      chk("hold_err", 32'(rsp_err), 32'(e_err));
      chk("hold_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("done_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("done_ready", 32'(req_ready), 32'd1);
    chk_array("done");
  endtask

  // Reset lands while the request is in EXEC (stage=1) or RESP (stage=2).
  task automatic abort_req(input logic [AW-1:0] addr, input logic [DW-1:0] wdata, input int stage);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    if (stage == 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    model_clear();
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk_array("abort");
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_rsp_valid2", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    model_clear();
    apply_reset();

    do_req(1'b1, 3'd2, 32'h0000_00F0, 0, 1'b0);
    do_req(1'b1, 3'd2, 32'h0000_000F, 0, 1'b0);
    do_req(1'b1, 3'd2, 32'h0000_0000, 0, 1'b0);
    do_req(1'b0, 3'd2, 32'h0,         0, 1'b0);
    do_req(1'b1, 3'd6, 32'hFFFF_FFFF, 0, 1'b0);
    do_req(1'b0, 3'd7, 32'h0,         0, 1'b0);
    do_req(1'b1, 3'd5, 32'h8000_0000, 0, 1'b0);
    do_req(1'b1, 3'd0, 32'h0000_0001, 0, 1'b0);
    do_req(1'b0, 3'd5, 32'h0,         0, 1'b0);
    do_req(1'b0, 3'd2, 32'h0,         5, 1'b1);
    abort_req(3'd1, 32'h0000_0004, 2);
    abort_req(3'd0, 32'h0000_0001, 1);

    for (int t = 0; t < 240; t++) begin
      if (t % 60 == 59) apply_reset();
      we    = 1'($urandom);
      addr  = AW'($urandom_range(0, 7));
      wdata = $urandom & $urandom & $urandom;
      do_req(we, addr, wdata, int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
